commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Hardware commit-trace recorder sitting directly downstream of `sccomp_dataflow`. Every cycle the CPU retires an instruction (`busy` low), it captures PC, instruction word and the register-file write into a FIFO, then serialises each record as four 32-bit words over a valid/ready stream. This lets the team drain execution traces from an FPGA board, e.g. over a UART/debug link, in the same pc/instr/register form the simulation trace uses.

## Interface
Parameters:
- `DEPTH`, 16: record FIFO depth; power of two, ≥2.
- `PC_START`, 32'h0040_0000: subtracted from captured PC to form word 0.

Ports:
- `clk_in`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `capture_en`  in  1  global capture enable.
- `busy`  in  1  CPU busy (multi-cycle mult/div in progress); 0 means an instruction retires this cycle.
- `pc`  in  32  PC of the retiring instruction.
- `inst`  in  32  instruction word of the retiring instruction.
- `rf_we`  in  1  register-file write enable of the retiring instruction.
- `rf_waddr`  in  5  destination register.
- `rf_wdata`  in  32  value written.
- `out_valid`  out  1  a trace word is presented.
- `out_ready`  in  1  consumer accepts the word when `out_valid & out_ready`.
- `out_data`  out  32  current trace word.
- `out_last`  out  1  high on word 3 of a record.
- `count`  out  $clog2(DEPTH)+1  records held, including the one being sent.
- `overflow`  out  1  sticky: at least one record was dropped.
- `drop_cnt`  out  16  dropped records, saturating at 16'hFFFF.

## Operation
- Capture condition: `reset==1 & capture_en & ~busy` at a rising edge is a push.
- Record fields: word0 = `pc - PC_START` (32-bit modular, wraps if pc < PC_START); word1 = `inst`; word2 = `rf_wdata`; word3 = {`we_eff`, 26'b0, `rf_waddr`}, where `we_eff = rf_we & (rf_waddr != 0)`. word2 is forced to 0 when `we_eff==0`.
- FIFO: circular, write/read pointers with one extra wrap bit. Full when `count==DEPTH`, empty when `count==0`.
- Serialiser: 2-bit word index `widx`, with `out_valid = (count != 0)`. `out_data` selects the head-record word `widx`. `out_last = out_valid & (widx==3)`.
- Handshake: on `out_valid & out_ready`, `widx` increments. On acceptance with `widx==3`, `widx` returns to 0 and the head record pops.
- While `out_valid & ~out_ready`, `out_data`/`out_last` stay stable; the producer never withdraws valid.
- Full + push without pop: record dropped; `overflow` set; `drop_cnt` increments, saturating.
- Full + push in the same cycle word 3 is accepted: pop and push both happen, nothing is dropped, `count` is unchanged.
- Empty + push: `count` goes to 1; the record is presented the next cycle. There is no bypass.
- `capture_en` low: no pushes; draining continues normally.
- Reset (`reset==0` at an edge), including mid-record: pointers, `count`, `widx`, `overflow` and `drop_cnt` go to 0; FIFO contents are discarded. Outputs after reset: `out_valid=0`, `out_last=0`, `out_data=0`, `count=0`, `overflow=0`, `drop_cnt=0`. `out_data` is 0 whenever `out_valid=0`.

## Timing
- Capture-to-`out_valid` latency: 1 cycle, when the FIFO was empty.
- Throughput: 1 word/cycle with `out_ready` held high, i.e. 4 cycles per record. The CPU retires up to 1 record/cycle, so a sustained burst overflows after DEPTH records in flight.
- `count`, `overflow` and `drop_cnt` are registered and update on the edge of the causing event.
- There is no combinational path from `out_ready` to `out_valid`. `out_data` depends only on registered state.

## Test plan
- Reset then a single retire with pc=32'h0040_0004, inst=32'h2001_0005, rf_we=1, waddr=1, wdata=5 and `out_ready=1` → one cycle later words 32'h4, 32'h2001_0005, 32'h5, 32'h8000_0001 on 4 consecutive cycles; `out_last` only on the 4th; `count` goes 1→0.
- `busy=1` for 10 cycles with `capture_en=1` → no pushes, `count=0`. Deasserting `busy` for 1 cycle → exactly one record.
- Write to $0 (rf_we=1, waddr=0, wdata=32'hFFFF_FFFF) → word2=0, word3=32'h0000_0000.
- `out_ready=0` and 20 consecutive retires with DEPTH=16 → `count=16`, `overflow=1`, `drop_cnt=4`. Then enable `out_ready` → exactly 64 words drain, in order.
- FIFO full, word 3 accepted in the same cycle as a new retire → `count` stays 16, `drop_cnt` unchanged. Random `out_ready` stalls → `out_data` stable during each stall.
- `reset` asserted while `widx==2` → next cycle `out_valid=0`, `count=0`, `drop_cnt=0`. The next capture starts at word 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: captures each retired instruction (pc/inst/rf write) into a
// record FIFO and streams every record out as four 32-bit words over valid/ready.
module commit_trace_buffer #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] PC_START = 32'h0040_0000
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic                     busy,
    input  logic [31:0]              pc,
    input  logic [31:0]              inst,
    input  logic                     rf_we,
    input  logic [4:0]               rf_waddr,
    input  logic [31:0]              rf_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] inst;
        logic [31:0] pc_off;
    } rec_t;

    rec_t        mem_q [DEPTH];
    rec_t        wr_rec;
    rec_t        head;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [1:0]  widx_q, widx_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        we_eff;
    logic        push_req;
    logic        full;
    logic        accept;
    logic        pop;
    logic        push;
    logic        drop;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        we_eff        = rf_we & (rf_waddr != 5'd0);
        wr_rec        = '0;
        wr_rec.we     = we_eff;
        wr_rec.waddr  = rf_waddr;
        wr_rec.wdata  = we_eff ? rf_wdata : 32'd0;
        wr_rec.inst   = inst;
        wr_rec.pc_off = pc - PC_START;

        push_req = reset & capture_en & ~busy;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        accept   = out_valid & out_ready;
        pop      = accept & (widx_q == 2'd3);
        // A pop frees the slot in the same cycle, so a full FIFO can still take the new record.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;

        wr_ptr_d   = push   ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
        widx_d     = accept ? widx_q + 2'd1   : widx_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: record storage is deliberately not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q[AW-1:0]];
        out_valid = (count_q != '0);
        out_last  = out_valid & (widx_q == 2'd3);
        out_data  = 32'd0;
        if (out_valid) begin
            case (widx_q)
                2'd0:    out_data = head.pc_off;
                2'd1:    out_data = head.inst;
                2'd2:    out_data = head.wdata;
                default: out_data = {head.we, 26'd0, head.waddr};
            endcase
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus randomized traffic,
// all compared against a queue-based record model.
module tb_commit_trace_buffer;

    localparam int          DEPTH    = 16;
    localparam logic [31:0] PC_START = 32'h0040_0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk_in = 1'b0;
    logic          reset = 1'b0;
    logic          capture_en = 1'b0;
    logic          busy = 1'b0;
    logic [31:0]   pc = '0;
    logic [31:0]   inst = '0;
    logic          rf_we = 1'b0;
    logic [4:0]    rf_waddr = '0;
    logic [31:0]   rf_wdata = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_last;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   drop_cnt;

    commit_trace_buffer #(.DEPTH(DEPTH), .PC_START(PC_START)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .capture_en (capture_en),
        .busy       (busy),
        .pc         (pc),
        .inst       (inst),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of whole records, word i of a record in bits [32*i +: 32].
    logic [127:0] mq[$];
    int           m_widx = 0;
    bit           m_ovf  = 1'b0;
    int           m_drop = 0;

    function automatic logic [127:0] make_rec();
        bit          we;
        logic [31:0] w2;
        we = rf_we && (rf_waddr != 5'd0);
        w2 = we ? rf_wdata : 32'd0;
        return {we, 26'd0, rf_waddr, w2, inst, pc - PC_START};
    endfunction

    task automatic model_update();
        if (!reset) begin
            mq.delete();
            m_widx = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            bit           acc;
            bit           pop;
            bit           push;
            logic [127:0] r;
            acc  = (mq.size() != 0) && out_ready;
            pop  = acc && (m_widx == 3);
            push = capture_en && !busy;
            r    = make_rec();
            if (acc) m_widx = (m_widx + 1) % 4;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(r);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit          ev;
        logic [31:0] ed;
        ev = (mq.size() != 0);
        ed = 32'd0;
        if (ev) ed = mq[0][m_widx*32 +: 32];
        check("out_valid", 32'(out_valid), 32'(ev));
        check("out_data",  out_data, ed);
        check("out_last",  32'(out_last), 32'(ev && m_widx == 3));
        check("count",     32'(count), 32'(mq.size()));
        check("overflow",  32'(overflow), 32'(m_ovf));
        check("drop_cnt",  32'(drop_cnt), 32'(m_drop));
    endtask

    // Inputs are set just after an edge; the model consumes them at the next edge.
    task automatic step();
        @(posedge clk_in);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic set_rec(input logic [31:0] p, input logic [31:0] i, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd);
        pc = p; inst = i; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    endtask

    initial begin
        int          n;
        logic [15:0] drop_saved;
        bit          pv, pr, prst;
        logic [31:0] pd;

        // Reset state
        reset = 1'b0;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Single retire, streamed with out_ready high
        reset = 1'b1; capture_en = 1'b1; busy = 1'b0; out_ready = 1'b1;
        set_rec(32'h0040_0004, 32'h2001_0005, 1'b1, 5'd1, 32'd5);
        step();
        capture_en = 1'b0;
        check("tp1_w0", out_data, 32'h0000_0004);
        check("tp1_cnt1", 32'(count), 32'd1);
        step();
        check("tp1_w1", out_data, 32'h2001_0005);
        step();
        check("tp1_w2", out_data, 32'h0000_0005);
        check("tp1_nolast", 32'(out_last), 32'd0);
        step();
        check("tp1_w3", out_data, 32'h8000_0001);
        check("tp1_last", 32'(out_last), 32'd1);
        step();
        check("tp1_cnt0", 32'(count), 32'd0);

        // Busy blocks capture; one non-busy cycle gives exactly one record
        capture_en = 1'b1; busy = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("busy_cnt0", 32'(count), 32'd0);
        busy = 1'b0;
        step();
        busy = 1'b1;
        step();
        check("busy_cnt1", 32'(count), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("busy_drained", 32'(count), 32'd0);

        // Write to $0 is not an effective write
        out_ready = 1'b0; busy = 1'b0;
        set_rec(32'h0040_0100, 32'h2000_ffff, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        capture_en = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("zero_w2", out_data, 32'd0);
        step();
        check("zero_w3", out_data, 32'd0);
        step();

        // Overflow: 20 retires into a 16-deep FIFO with no drain
        out_ready = 1'b0; capture_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_rec(PC_START + 32'(4 * k), 32'(k), 1'b1, 5'(k + 1), 32'(k * 3));
            step();
        end
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_cnt), 32'd4);
        capture_en = 1'b0; out_ready = 1'b1;
        check("drain_first", out_data, 32'd0);
        n = 0;
        for (int k = 0; k < 100 && out_valid; k++) begin
            n++;
            step();
        end
        check("drain_words", 32'(n), 32'd64);

        // Full FIFO: pop and push in the same cycle
        out_ready = 1'b0; capture_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_rec(32'h1000_0000 + 32'(k), $urandom, 1'b1, 5'd7, $urandom);
            step();
        end
        check("full_count", 32'(count), 32'd16);
        drop_saved = drop_cnt;
        capture_en = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("full_at_w3", 32'(out_last), 32'd1);
        capture_en = 1'b1; busy = 1'b0;
        step();
        check("swap_count", 32'(count), 32'd16);
        check("swap_drops", 32'(drop_cnt), 32'(drop_saved));

        // Randomized traffic with stall-stability checks
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 79) != 0);
            capture_en = ($urandom_range(0, 3) != 0);
            busy       = ($urandom_range(0, 2) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            set_rec($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            pv = out_valid; pd = out_data; pr = out_ready; prst = reset;
            step();
            if (pv && !pr && prst) check("stall_stable", out_data, pd);
        end

        // Reset in the middle of a record
        reset = 1'b0; capture_en = 1'b0;
        step();
        reset = 1'b1; capture_en = 1'b1; busy = 1'b0; out_ready = 1'b0;
        set_rec(32'h0040_0200, 32'h1234_5678, 1'b1, 5'd9, 32'hCAFE_0001);
        step();
        capture_en = 1'b0; out_ready = 1'b1;
        step();
        step();
        check("mid_w2", out_data, 32'hCAFE_0001);
        reset = 1'b0;
        step();
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_count", 32'(count), 32'd0);
        check("mid_drops", 32'(drop_cnt), 32'd0);
        reset = 1'b1; capture_en = 1'b1;
        set_rec(32'h0040_0010, 32'h0000_0001, 1'b0, 5'd3, 32'd0);
        step();
        capture_en = 1'b0;
        check("post_rst_w0", out_data, 32'h0000_0010);
        check("post_rst_last", 32'(out_last), 32'd0);
        for (int k = 0; k < 4; k++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
